// File: rtl/sprite_rect_driver_if.sv
// sprite_rect_driver_if
//   Groups the scan/frame inputs and the sprite outputs of sprite_rect_driver.
//   There is no valid/ready handshake on this bus: startOfFrame, hitX and hitY
//   are single-cycle strobes sampled on every rising clock edge, freeze is a
//   level that only matters in the startOfFrame cycle, and pixelX/pixelY are
//   sampled every cycle with results appearing one cycle later.
//
//   Signals
//     startOfFrame    frame-start strobe (during blanking)
//     pixelX, pixelY  current scan coordinates
//     freeze          level; a frame start seen while high does not move the sprite
//     hitX, hitY      collision strobes; reverse X / Y direction at next update
//     InsideRectangle scan pixel lies inside the sprite (registered)
//     offsetX/Y       pixel position relative to sprite top-left (registered)
//     topLeftX/Y      current sprite top-left corner
//     dbg_state       motion FSM state (0 idle, 1 updating X, 2 updating Y)
//
//   Modports
//     master  drives the scan/frame inputs (video timing side / testbench)
//     slave   the sprite driver itself
interface sprite_rect_driver_if;
  logic        startOfFrame;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        freeze;
  logic        hitX;
  logic        hitY;
  logic        InsideRectangle;
  logic [10:0] offsetX;
  logic [10:0] offsetY;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic [1:0]  dbg_state;

  modport master (
    output startOfFrame, pixelX, pixelY, freeze, hitX, hitY,
    input  InsideRectangle, offsetX, offsetY, topLeftX, topLeftY, dbg_state
  );

  modport slave (
    input  startOfFrame, pixelX, pixelY, freeze, hitX, hitY,
    output InsideRectangle, offsetX, offsetY, topLeftX, topLeftY, dbg_state
  );
endinterface

// File: rtl/sprite_rect_driver.sv
// sprite_rect_driver
//   Moves a rectangular sprite once per video frame and tells the pixel
//   pipeline whether the current scan pixel falls inside it.
//
//   Once per frame (startOfFrame with freeze low) a small FSM steps through
//   UPD_X then UPD_Y. Each step adds the axis velocity to the position, after
//   optionally reversing it for a pending collision, and bounces off the
//   screen edges. The two axes share one adder/clamp datapath.
//
//   Ports
//     clk     single clock
//     resetN  asynchronous active-low reset
//     bus     sprite_rect_driver_if.slave (scan inputs, sprite outputs)
module sprite_rect_driver #(
  parameter int OBJECT_WIDTH_X  = 32,
  parameter int OBJECT_HEIGHT_Y = 20,
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480,
  parameter int INITIAL_X       = 280,
  parameter int INITIAL_Y       = 185,
  parameter int INITIAL_VX      = 2,
  parameter int INITIAL_VY      = -1
) (
  input logic                 clk,
  input logic                 resetN,
  sprite_rect_driver_if.slave bus
);

  // Largest legal top-left coordinate on each axis.
  localparam logic signed [11:0] MAX_X = 12'(SCREEN_W - OBJECT_WIDTH_X);
  localparam logic signed [11:0] MAX_Y = 12'(SCREEN_H - OBJECT_HEIGHT_Y);
  localparam logic [11:0]        SIZE_X = 12'(OBJECT_WIDTH_X);
  localparam logic [11:0]        SIZE_Y = 12'(OBJECT_HEIGHT_Y);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UPD_X = 2'd1,
    UPD_Y = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   upd_x;
  logic   upd_y;

  // Sprite motion registers
  logic [10:0]       pos_x;
  logic [10:0]       pos_y;
  logic signed [7:0] vel_x;
  logic signed [7:0] vel_y;
  logic              flag_x;
  logic              flag_y;

  // Shared axis datapath
  logic [10:0]        sel_pos;
  logic signed [7:0]  sel_vel;
  logic               sel_flag;
  logic signed [11:0] sel_max;
  logic signed [7:0]  v_eff;
  logic signed [7:0]  v_mag;
  logic signed [11:0] sum;
  logic [10:0]        new_pos;
  logic signed [7:0]  new_vel;

  // Scan bracket
  logic [11:0] pix_x;
  logic [11:0] pix_y;
  logic [11:0] left;
  logic [11:0] top;
  logic        in_x;
  logic        in_y;
  logic [10:0] dx;
  logic [10:0] dy;
  logic        inside_q;
  logic [10:0] off_x_q;
  logic [10:0] off_y_q;

  // Negation that never yields -128: -(-128) saturates to +127.
  function automatic logic signed [7:0] neg_sat(input logic signed [7:0] v);
    if (v[7] && (v[6:0] == 7'd0)) begin
      return 8'sd127;
    end
    return -v;
  endfunction

  // ---------------------------------------------------------------------
  // Motion FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A frame start is only honoured from IDLE, so a strobe that lands while
  // an update is in progress is simply dropped.
  always_comb begin
    state_next = state;
    upd_x      = 1'b0;
    upd_y      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.startOfFrame && !bus.freeze) begin
          state_next = UPD_X;
        end
      end
      UPD_X: begin
        upd_x      = 1'b1;
        state_next = UPD_Y;
      end
      UPD_Y: begin
        upd_y      = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Axis step: pick the axis being updated, apply pending reversal, add,
  // then clamp to the screen. A wall bounce sets the direction explicitly,
  // so it wins over any collision reversal on the same step.
  // ---------------------------------------------------------------------
  always_comb begin
    sel_pos  = pos_x;
    sel_vel  = vel_x;
    sel_flag = flag_x;
    sel_max  = MAX_X;
    if (upd_y) begin
      sel_pos  = pos_y;
      sel_vel  = vel_y;
      sel_flag = flag_y;
      sel_max  = MAX_Y;
    end

    v_eff = sel_flag ? neg_sat(sel_vel) : sel_vel;
    v_mag = v_eff[7] ? neg_sat(v_eff) : v_eff;
    sum   = $signed({1'b0, sel_pos}) + $signed({{4{v_eff[7]}}, v_eff});

    new_pos = sum[10:0];
    new_vel = v_eff;
    if (sum[11]) begin
      new_pos = 11'd0;
      new_vel = v_mag;
    end else if (sum > sel_max) begin
      new_pos = sel_max[10:0];
      new_vel = -v_mag;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pos_x  <= 11'(INITIAL_X);
      pos_y  <= 11'(INITIAL_Y);
      vel_x  <= 8'(INITIAL_VX);
      vel_y  <= 8'(INITIAL_VY);
      flag_x <= 1'b0;
      flag_y <= 1'b0;
    end else begin
      if (upd_x) begin
        pos_x <= new_pos;
        vel_x <= new_vel;
      end
      if (upd_y) begin
        pos_y <= new_pos;
        vel_y <= new_vel;
      end
      // The flag is consumed by its own update; a hit arriving in that very
      // cycle is loaded instead of lost, so it applies to the next frame.
      flag_x <= upd_x ? bus.hitX : (flag_x | bus.hitX);
      flag_y <= upd_y ? bus.hitY : (flag_y | bus.hitY);
    end
  end

  // ---------------------------------------------------------------------
  // Scan bracket. Compared in 12 bits so pos + size cannot wrap.
  // ---------------------------------------------------------------------
  always_comb begin
    pix_x = {1'b0, bus.pixelX};
    pix_y = {1'b0, bus.pixelY};
    left  = {1'b0, pos_x};
    top   = {1'b0, pos_y};
    in_x  = (pix_x >= left) && (pix_x < (left + SIZE_X));
    in_y  = (pix_y >= top)  && (pix_y < (top + SIZE_Y));
    dx    = bus.pixelX - pos_x;
    dy    = bus.pixelY - pos_y;
  end

  // Pixel and position registers are sampled on the same edge, so a
  // position change can only shift the bracket between two adjacent pixels.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      inside_q <= 1'b0;
      off_x_q  <= 11'd0;
      off_y_q  <= 11'd0;
    end else begin
      inside_q <= in_x && in_y;
      off_x_q  <= (in_x && in_y) ? dx : 11'd0;
      off_y_q  <= (in_x && in_y) ? dy : 11'd0;
    end
  end

  assign bus.InsideRectangle = inside_q;
  assign bus.offsetX         = off_x_q;
  assign bus.offsetY         = off_y_q;
  assign bus.topLeftX        = pos_x;
  assign bus.topLeftY        = pos_y;
  assign bus.dbg_state       = state;

endmodule
